// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Shared definitions for the multi-cycle MIPS control unit:
//   - opcode / funct constants of the supported instruction subset
//   - 4-bit sequencing state enum (15 states)
//   - datapath mux-select encodings (ALUOp, ALU B source, reg_dst,
//     mem_to_reg, pc_source)
//   - ctrl_t: the full control vector driven by the output decoder
//   - is_known_op(): true for every opcode the sequencer implements
package mips_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // funct (IR[5:0]) for R-type
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_ADDI_EX   = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_JAL       = 4'd13,
        S_JR        = 4'd14
    } state_t;

    // ALU control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B source
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Write-register select
    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    // Write-data select
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    // PC source
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J)    || (op == OP_JAL) ||
               (op == OP_BEQ)   || (op == OP_BNE)  || (op == OP_ADDI) ||
               (op == OP_LW)    || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// mips_mc_outdec
//   Purely combinational state -> control-vector decoder.
//   Ports:
//     state     in  current sequencer state
//     opcode    in  IR opcode (only for branch_ne and illegal)
//     mem_ready in  memory completion (only gates FETCH ir_write/pc_write)
//     ctrl      out full datapath control vector; all zero unless set below
module mips_mc_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                // Memory selects are held constant for every wait cycle;
                // only the IR/PC load waits for the data to arrive.
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.illegal   = ~is_known_op(opcode);
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RDST_RT;
                ctrl.mem_to_reg = WB_MDR;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RDST_RD;
                ctrl.mem_to_reg = WB_ALUOUT;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RDST_RT;
                ctrl.mem_to_reg = WB_ALUOUT;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                // beq = 000100, bne = 000101: bit 0 selects the inverted zero.
                ctrl.branch_ne     = opcode[0];
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so writing the pre-edge
                // PC into $31 gives the link address in the same cycle.
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RDST_RA;
                ctrl.mem_to_reg = WB_PC;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
            end
            S_JR: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_REG;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Moore sequencing FSM for the multi-cycle MIPS datapath. Holds the
//   state register, next-state logic and the retired-instruction counter;
//   the control vector is decoded from the state by mips_mc_outdec.
//   Ports:
//     clk, rst_n        clock (rising edge), async active-low reset
//     opcode, funct     IR fields, stable from end of FETCH to next FETCH
//     mem_ready         memory finished the current access this cycle
//     pc_write .. pc_source   datapath mux selects and write enables
//     illegal           one-cycle pulse in DECODE on an unsupported opcode
//     retired           retired-instruction count, wraps modulo 2^CNT_W
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    ctrl_t            ctrl;

    // Next-state logic. Memory states hold until mem_ready; an unknown
    // opcode falls straight back to FETCH with nothing written.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:     state_d = S_FETCH;
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_RTYPE:       state_d = (funct == FN_JR) ? S_JR : S_EXECUTE;
                    OP_ADDI:        state_d = S_ADDI_EX;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_JAL:         state_d = S_JAL;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_ADDI_EX:   state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_JAL:       state_d = S_FETCH;
            S_JR:        state_d = S_FETCH;
            default:     state_d = S_RESET;
        endcase
    end

    // An instruction retires when it returns to FETCH from its last step.
    // RESET->FETCH and the illegal DECODE->FETCH path are excluded because
    // DECODE and RESET are not in this list.
    always_comb begin
        retire = 1'b0;
        if (state_d == S_FETCH) begin
            case (state_q)
                S_MEM_WB, S_MEM_WRITE, S_R_WB, S_ADDI_WB,
                S_BRANCH, S_JUMP, S_JAL, S_JR: retire = 1'b1;
                default:                       retire = 1'b0;
            endcase
        end
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    mips_mc_outdec u_outdec (
        .state     (state_q),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign branch_ne     = ctrl.branch_ne;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign illegal       = ctrl.illegal;
    assign retired       = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//   Directed bench for the multi-cycle MIPS control FSM. A 4-bit retired
//   counter is used so the wrap can be reached with a handful of jumps.
//   The observed control word packs every control output in the order
//   {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
//    ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
//    alu_op, pc_source, illegal} and is compared to hand-built constants.
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 4;

    //                              pw/pwc/bne/iord mr/mw/irw/rw rd mtr a b  op ps ill
    localparam logic [19:0] C_ZERO     = 20'b0000_0000_00_00_0_00_00_00_0;
    localparam logic [19:0] C_FETCH_R  = 20'b1000_1010_00_00_0_01_00_00_0;
    localparam logic [19:0] C_FETCH_W  = 20'b0000_1000_00_00_0_01_00_00_0;
    localparam logic [19:0] C_DECODE   = 20'b0000_0000_00_00_0_11_00_00_0;
    localparam logic [19:0] C_DEC_ILL  = 20'b0000_0000_00_00_0_11_00_00_1;
    localparam logic [19:0] C_MEM_ADDR = 20'b0000_0000_00_00_1_10_00_00_0;
    localparam logic [19:0] C_MEM_RD   = 20'b0001_1000_00_00_0_00_00_00_0;
    localparam logic [19:0] C_MEM_WB   = 20'b0000_0001_00_01_0_00_00_00_0;
    localparam logic [19:0] C_MEM_WR   = 20'b0001_0100_00_00_0_00_00_00_0;
    localparam logic [19:0] C_EXECUTE  = 20'b0000_0000_00_00_1_00_10_00_0;
    localparam logic [19:0] C_R_WB     = 20'b0000_0001_01_00_0_00_00_00_0;
    localparam logic [19:0] C_ADDI_EX  = 20'b0000_0000_00_00_1_10_00_00_0;
    localparam logic [19:0] C_ADDI_WB  = 20'b0000_0001_00_00_0_00_00_00_0;
    localparam logic [19:0] C_BNE      = 20'b0110_0000_00_00_1_00_01_01_0;
    localparam logic [19:0] C_BEQ      = 20'b0100_0000_00_00_1_00_01_01_0;
    localparam logic [19:0] C_JUMP     = 20'b1000_0000_00_00_0_00_00_10_0;
    localparam logic [19:0] C_JAL      = 20'b1000_0001_10_10_0_00_00_10_0;
    localparam logic [19:0] C_JR       = 20'b1000_0000_00_00_0_00_00_11_0;

    logic             clk;
    logic             rst_n;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             pc_write, pc_write_cond, branch_ne, iord;
    logic             mem_read, mem_write, ir_write, reg_write;
    logic [1:0]       reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
    logic             alu_src_a, illegal;
    logic [CNT_W-1:0] retired;
    logic [19:0]      ctrl_obs;

    int n_checks = 0;
    int n_fail   = 0;

    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal       (illegal),
        .retired       (retired)
    );

    assign ctrl_obs = {pc_write, pc_write_cond, branch_ne, iord, mem_read,
                       mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                       alu_src_a, alu_src_b, alu_op, pc_source, illegal};

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after an active edge: drive mem_ready, check the control
    // word for the current state, then advance one clock.
    task automatic step(input string tag, input logic rdy,
                        input logic [19:0] exp_ctrl);
        mem_ready = rdy;
        #1;
        check(tag, 32'(ctrl_obs), 32'(exp_ctrl));
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    task automatic run_jump(input string tag);
        set_ir(6'b000010, 6'b000000);
        step({tag, "_fetch"}, 1'b1, C_FETCH_R);
        step({tag, "_decode"}, 1'b1, C_DECODE);
        step({tag, "_jump"}, 1'b1, C_JUMP);
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        set_ir(6'b000000, 6'b100000);   // add
        repeat (2) @(posedge clk);
        #1;
        check("in_reset_ctrl", 32'(ctrl_obs), 32'(C_ZERO));
        check("in_reset_retired", 32'(retired), 32'd0);
        rst_n = 1'b1;

        // First cycle after release is still RESET, then FETCH.
        step("reset_cycle", 1'b1, C_ZERO);
        check("first_fetch_retired", 32'(retired), 32'd0);

        // R-type add: 4 cycles
        step("add_fetch", 1'b1, C_FETCH_R);
        step("add_decode", 1'b1, C_DECODE);
        step("add_execute", 1'b1, C_EXECUTE);
        step("add_rwb", 1'b1, C_R_WB);
        check("retired_after_add", 32'(retired), 32'd1);

        // lw with 3 FETCH waits and 2 MEM_READ waits: 10 cycles
        set_ir(6'b100011, 6'b000000);
        for (int i = 0; i < 3; i++) step("lw_fetch_wait", 1'b0, C_FETCH_W);
        step("lw_fetch", 1'b1, C_FETCH_R);
        step("lw_decode", 1'b0, C_DECODE);
        step("lw_memaddr", 1'b0, C_MEM_ADDR);
        for (int i = 0; i < 2; i++) step("lw_memread_wait", 1'b0, C_MEM_RD);
        step("lw_memread", 1'b1, C_MEM_RD);
        step("lw_memwb", 1'b1, C_MEM_WB);
        check("retired_after_lw", 32'(retired), 32'd2);

        // bne then beq: 3 cycles each
        set_ir(6'b000101, 6'b000000);
        step("bne_fetch", 1'b1, C_FETCH_R);
        step("bne_decode", 1'b1, C_DECODE);
        step("bne_branch", 1'b1, C_BNE);
        check("retired_after_bne", 32'(retired), 32'd3);
        set_ir(6'b000100, 6'b000000);
        step("beq_fetch", 1'b1, C_FETCH_R);
        step("beq_decode", 1'b1, C_DECODE);
        step("beq_branch", 1'b1, C_BEQ);
        check("retired_after_beq", 32'(retired), 32'd4);

        // jal then jr
        set_ir(6'b000011, 6'b000000);
        step("jal_fetch", 1'b1, C_FETCH_R);
        step("jal_decode", 1'b1, C_DECODE);
        step("jal_jal", 1'b1, C_JAL);
        check("retired_after_jal", 32'(retired), 32'd5);
        set_ir(6'b000000, 6'b001000);
        step("jr_fetch", 1'b1, C_FETCH_R);
        step("jr_decode", 1'b1, C_DECODE);
        step("jr_jr", 1'b1, C_JR);
        check("retired_after_jr", 32'(retired), 32'd6);

        // Illegal opcode: one-cycle illegal pulse, back to FETCH, no retire
        set_ir(6'b111111, 6'b000000);
        step("ill_fetch", 1'b1, C_FETCH_R);
        step("ill_decode", 1'b1, C_DEC_ILL);
        check("retired_after_illegal", 32'(retired), 32'd6);

        // sw with one MEM_WRITE wait
        set_ir(6'b101011, 6'b000000);
        step("sw_fetch", 1'b1, C_FETCH_R);
        step("sw_decode", 1'b1, C_DECODE);
        step("sw_memaddr", 1'b1, C_MEM_ADDR);
        step("sw_memwrite_wait", 1'b0, C_MEM_WR);
        step("sw_memwrite", 1'b1, C_MEM_WR);
        check("retired_after_sw", 32'(retired), 32'd7);

        // addi: 4 cycles
        set_ir(6'b001000, 6'b000000);
        step("addi_fetch", 1'b1, C_FETCH_R);
        step("addi_decode", 1'b1, C_DECODE);
        step("addi_ex", 1'b1, C_ADDI_EX);
        step("addi_wb", 1'b1, C_ADDI_WB);
        check("retired_after_addi", 32'(retired), 32'd8);

        // Seven jumps take the 4-bit counter to 15, the next one wraps to 0
        for (int i = 0; i < 7; i++) run_jump("j");
        check("retired_at_max", 32'(retired), 32'd15);
        run_jump("j_wrap");
        check("retired_wrapped", 32'(retired), 32'd0);
        run_jump("j_post_wrap");
        check("retired_post_wrap", 32'(retired), 32'd1);

        // Async reset while stalled in MEM_WRITE
        set_ir(6'b101011, 6'b000000);
        step("sw2_fetch", 1'b1, C_FETCH_R);
        step("sw2_decode", 1'b1, C_DECODE);
        step("sw2_memaddr", 1'b0, C_MEM_ADDR);
        mem_ready = 1'b0;
        #1;
        check("sw2_memwrite_wait", 32'(ctrl_obs), 32'(C_MEM_WR));
        rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", 32'(ctrl_obs), 32'(C_ZERO));
        check("async_reset_retired", 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        check("held_reset_ctrl", 32'(ctrl_obs), 32'(C_ZERO));
        rst_n = 1'b1;

        // Refetch after abort
        set_ir(6'b000010, 6'b000000);
        step("rst2_cycle", 1'b1, C_ZERO);
        run_jump("refetch");
        check("retired_after_refetch", 32'(retired), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style sequencing FSM for the multi-cycle MIPS datapath, the successor to the single-cycle combinational decoder.
- Shares one memory port, one ALU and one register-file write port across the fetch, decode, execute, memory and writeback steps.
- Takes opcode and funct from the instruction register (IR).
- Drives every datapath mux select and write enable, and counts retired instructions.
- Handles a variable-latency memory through a ready handshake.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; IR is stable from the end of FETCH until the next FETCH.
- funct  in  6  IR[5:0].
- mem_ready  in  1  memory completed the access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by the ALU zero flag.
- branch_ne  out  1  invert the zero flag for bne.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- reg_write  out  1  register-file write.
- reg_dst  out  2  write register select: 00 = rt, 01 = rd, 10 = $31.
- mem_to_reg  out  2  write data select: 00 = ALUOut, 01 = MDR, 10 = PC.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = reg A.
- alu_src_b  out  2  ALU B select: 00 = reg B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- alu_op  out  2  ALU control: 00 = add, 01 = sub, 10 = funct-decoded.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = reg A (jr).
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (async, rst_n=0): state = RESET, retired = 0. Every output is 0 whenever in RESET.
- RESET always goes to FETCH on the next clock.
- Outputs are decoded from the state only, except for the explicitly qualified signals. Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write = pc_write = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state:
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR.
  - 000000 with funct 001000 -> JR; 000000 with any other funct -> EXECUTE.
  - 001000 (addi) -> ADDI_EX.
  - 000100 (beq) or 000101 (bne) -> BRANCH.
  - 000010 (j) -> JUMP.
  - 000011 (jal) -> JAL.
  - any other opcode -> illegal=1 for this cycle, then FETCH; no architectural write.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_READ if opcode=lw, else MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. Wait for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
- MEM_WRITE: mem_write=1, iord=1. Wait for mem_ready, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00 -> FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=00, mem_to_reg=00 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, branch_ne=opcode[0], pc_source=01 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- JAL: reg_write=1, reg_dst=10, mem_to_reg=10, pc_write=1, pc_source=10 -> FETCH.
  - The register file captures the pre-edge PC, which already holds PC+4, as the link address.
- JR: pc_write=1, pc_source=11 -> FETCH.
- Memory handshake:
  - mem_read/mem_write stay asserted, with address selects unchanged, for every wait cycle.
  - A stall of any length is legal.
- mem_read and mem_write are never asserted together. reg_write and mem_write are never asserted together.
- retired:
  - Increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, ADDI_WB, BRANCH, JUMP, JAL or JR.
  - Does not increment on RESET->FETCH or on illegal DECODE->FETCH.
  - Wraps modulo 2^CNT_W.
- Cycle counts with zero memory wait: lw 5; sw, R-type and addi 4; beq, bne, j, jal and jr 3.
- Reset mid-instruction aborts immediately. The next instruction is refetched from whatever the PC holds.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct constants;
  - the 4-bit state enum (15 states: RESET, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, ADDI_EX, ADDI_WB, BRANCH, JUMP, JAL, JR);
  - the ALUOp, alu_src_b, reg_dst, mem_to_reg and pc_source encodings.
- One natural sub-module: mips_mc_outdec, a purely combinational state-to-control-vector decoder. The top keeps the state register, next-state logic and counter.

Test Plan:
- Reset, then release with mem_ready=1: first cycle in RESET with all outputs 0, next cycle FETCH with mem_read=1, pc_write=1, ir_write=1. retired stays 0.
- lw (100011) with mem_ready held 0 for 3 cycles in FETCH and 2 in MEM_READ: ir_write fires only on the ready cycle, the state sequence totals 10 cycles, MEM_WB shows reg_write=1 / mem_to_reg=01 / reg_dst=00, and retired=1.
- bne (000101) then beq (000100): BRANCH shows pc_write_cond=1, alu_op=01, pc_source=01, with branch_ne=1 then 0. Each takes 3 cycles and retired=2.
- jal (000011): the JAL cycle has reg_dst=10, mem_to_reg=10, reg_write=1, pc_write=1, pc_source=10. Then R-type with funct 001000 goes to JR with pc_source=11 and reg_write=0.
- Opcode 111111: illegal pulses exactly one cycle in DECODE, then FETCH. No reg_write or mem_write is asserted and retired is unchanged.
- Preload retired to 2^CNT_W-1 by sequence (or CNT_W=4 with 15 instructions); the next retire wraps it to 0. Assert rst_n=0 during MEM_WRITE: mem_write drops in the same cycle (async) and retired clears to 0.
